uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

Parametrised UART receive engine; successor to the fixed 8N1 receiver. Adds configurable data width, parity and stop bits, a 2-flop input synchroniser, false-start rejection, per-frame error tagging and a buffered ready/valid output through an internal FIFO. Sits between the board `rx` pin and the display command parser.

## Interface
- `CLK_PER_BIT`, 434: clocks per bit (115200 baud @ 50 MHz); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY_MODE`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: RX FIFO entries, power of 2, ≥ 2.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, asynchronous, idle high.
- `rd_data`  out  DATA_BITS  head-of-FIFO data.
- `rd_err`  out  2  head-of-FIFO tag: [0] framing error, [1] parity error.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer pops when `rd_valid && rd_ready`.
- `overrun`  out  1  sticky: frame dropped because FIFO was full.
- `clr_overrun`  in  1  clears `overrun`.
- `busy`  out  1  FSM not in IDLE/WAIT_IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`); all logic uses `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: on `rx_s` = 0, clear bit counter `cnt` (width $clog2(CLK_PER_BIT)) and go to START. That cycle is t=0.
- START: at t = HALF (HALF = CLK_PER_BIT/2, floor), sample. Low → DATA; high → false start, back to IDLE with nothing written.
- DATA: data bit k (LSB first) is sampled at t = HALF + (k+1)·CLK_PER_BIT, k = 0..DATA_BITS-1. Then PARITY if `PARITY_MODE` ≠ 0, else STOP.
- PARITY: one bit sampled. Parity error when XOR of data and parity bit is 0 (odd) or 1 (even).
- STOP: samples `STOP_BITS` stop bits. Framing error if any of them is low.
- After the last stop sample, the frame {data, errors} is written to the FIFO on the next edge.
  - Framing error → WAIT_IDLE, which holds until `rx_s` = 1, then IDLE (a break yields exactly one frame).
  - Otherwise → IDLE directly, so the next start bit can be detected from mid-stop.
- Frames with errors are still stored, tagged via `rd_err`. The consumer decides what to do with them.
- FIFO full at write time → frame discarded, `overrun` set. Set has priority over a same-cycle `clr_overrun`.
- Full FIFO with a pop and a write in the same cycle → write accepted, count unchanged.
- `reset_n` low mid-frame → FSM to IDLE, FIFO emptied, partial frame lost. Synchroniser flops reset to 1.

## Timing
- Reset values: `rd_valid` 0, `rd_data` 0, `rd_err` 0, `overrun` 0, `busy` 0.
- Pin-to-FSM latency: 2 cycles (synchroniser).
- Last stop sample at cycle S → FIFO write at edge S+1 → `rd_valid` high after that edge. `rd_data`/`rd_err` are valid from the same edge.
- Pop at edge E → next entry (or `rd_valid` = 0) is visible after E. No combinational path from `rd_ready` to `rd_valid`.
- `rd_data`/`rd_err` stay stable while `rd_valid && !rd_ready`.
- `busy` rises the cycle after start detection and falls when the FSM enters IDLE/WAIT_IDLE.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - every bit (start, data, parity, stop) is the 2-of-3 majority of `rx_s` at mid−1, mid and mid+1;
  - the decision and any FSM transition happen at mid+1, so all sample times above shift by +1 cycle;
  - a single-cycle glitch at mid does not corrupt a bit.
- Undefined: one sample at mid, timing exactly as stated above.

## Structure
- Package `uart_rx_pkg` holds:
  - FSM state enum;
  - parity-mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - `rd_err` bit indices `ERR_FRAME`, `ERR_PARITY`.
- Sub-module `uart_rx_fifo`: synchronous FIFO, width DATA_BITS+2, depth FIFO_DEPTH, asynchronous active-low reset, full/empty from pointers with an extra wrap bit.
- Synchroniser, sampler and FSM live in `uart_rx_engine`.

## Test plan
All scenarios use CLK_PER_BIT=16, DATA_BITS=8, PARITY_MODE=2, STOP_BITS=1, FIFO_DEPTH=4 unless noted.
- Send 0x41 with correct even parity → `rd_valid` 1 cycle after the stop sample, `rd_data`=0x41, `rd_err`=0.
- Send 0x41 with flipped parity bit → `rd_data`=0x41, `rd_err`=2'b10.
- Stop bit driven low, then `rx` held low 40 bit times → exactly one entry, `rd_err`[0]=1, FSM in WAIT_IDLE until `rx` goes high.
- 6-cycle low pulse on idle `rx` → no FIFO write, `busy` returns to 0 by cycle HALF+1.
- `rd_ready`=0, send 5 frames 0x01..0x05 → FIFO holds 0x01..0x04, `overrun`=1. Pop all 4 in order, then `clr_overrun` → `overrun`=0.
- With `UART_RX_MAJORITY_EN`: 1-cycle inverted glitch at the mid of data bit 3 of 0x55 → 0x55 received, no error. Without the macro the same stimulus → 0x5D.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive engine.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Bit positions inside rd_err
    localparam int unsigned ERR_FRAME  = 0;
    localparam int unsigned ERR_PARITY = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with wrap-bit pointers; read data is the
// head entry, forced to zero while empty.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_rd = i_rd_en && !o_empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is taken
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + 1'b1;
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: parametrised UART receiver with synchroniser, false-start
// rejection, per-frame error tags and a buffered ready/valid output.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit,
// decision one cycle later than single-sample mode.
module uart_rx_engine
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 434,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rd_data,
    output logic [1:0]           rd_err,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic                 overrun,
    input  logic                 clr_overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned HALF  = CLK_PER_BIT / 2;
    // r_cnt reads 0 one cycle after start detection, so mid sits at HALF-1
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned START_AT = HALF;
`else
    localparam int unsigned START_AT = HALF - 1;
`endif
    localparam int unsigned BIT_AT    = CLK_PER_BIT - 1;
    localparam int unsigned LAST_BIT  = DATA_BITS - 1;
    localparam int unsigned LAST_STOP = STOP_BITS - 1;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 w_rx_s;
    logic                 w_bit;
    rx_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [3:0]           r_bit_idx, w_bit_idx_nxt;
    logic                 r_stop_idx, w_stop_idx_nxt;
    logic [DATA_BITS-1:0] r_data, w_data_nxt;
    logic                 r_perr, w_perr_nxt;
    logic                 r_ferr, w_ferr_nxt;
    logic                 w_at_bit;
    logic                 w_par_x;
    logic                 w_wr_en;
    logic [1:0]           w_wr_err;
    logic [DATA_BITS+1:0] w_wr_data;
    logic [DATA_BITS+1:0] w_rd_word;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pop;
    logic                 r_overrun;

    assign w_rx_s = r_sync2;

    // Two-flop synchroniser, idle-high after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Keep the two previous rx_s samples for the 3-sample vote
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_hist <= 2'b11;
        else          r_hist <= {r_hist[0], w_rx_s};
    end

    assign w_bit = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    assign w_at_bit = (r_cnt == CNT_W'(BIT_AT));
    assign w_par_x  = ^{r_data, w_bit};

    // FSM and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_data     <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_data     <= w_data_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
        end
    end

    // Next-state, bit sampling and frame write request
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_data_nxt     = r_data;
        w_perr_nxt     = r_perr;
        w_ferr_nxt     = r_ferr;
        w_wr_en        = 1'b0;
        w_wr_err       = '0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            START: begin
                if (r_cnt == CNT_W'(START_AT)) begin
                    w_cnt_nxt = '0;
                    if (w_bit) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt    = DATA;
                        w_bit_idx_nxt  = '0;
                        w_stop_idx_nxt = 1'b0;
                        w_perr_nxt     = 1'b0;
                        w_ferr_nxt     = 1'b0;
                    end
                end
            end
            DATA: begin
                if (w_at_bit) begin
                    w_cnt_nxt     = '0;
                    w_data_nxt    = {w_bit, r_data[DATA_BITS-1:1]};
                    w_bit_idx_nxt = r_bit_idx + 4'd1;
                    if (r_bit_idx == 4'(LAST_BIT))
                        w_state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_at_bit) begin
                    w_cnt_nxt   = '0;
                    w_perr_nxt  = (PARITY_MODE == PAR_ODD) ? ~w_par_x : w_par_x;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_at_bit) begin
                    w_cnt_nxt      = '0;
                    w_ferr_nxt     = r_ferr | ~w_bit;
                    w_stop_idx_nxt = 1'b1;
                    if (r_stop_idx == 1'(LAST_STOP)) begin
                        w_wr_en              = 1'b1;
                        w_wr_err[ERR_FRAME]  = r_ferr | ~w_bit;
                        w_wr_err[ERR_PARITY] = r_perr;
                        w_state_nxt = (r_ferr | ~w_bit) ? WAIT_IDLE : IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_rx_s) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_wr_data = {w_wr_err, r_data};
    assign w_pop     = !w_empty && rd_ready;

    uart_rx_fifo #(
        .WIDTH(DATA_BITS + 2),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_wr_en  (w_wr_en),
        .i_wr_data(w_wr_data),
        .i_rd_en  (rd_ready),
        .o_rd_data(w_rd_word),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Sticky overrun; a drop in the same cycle wins over the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                        r_overrun <= 1'b0;
        else if (w_wr_en && w_full && !w_pop) r_overrun <= 1'b1;
        else if (clr_overrun)                r_overrun <= 1'b0;
    end

    assign rd_data  = w_rd_word[DATA_BITS-1:0];
    assign rd_err   = w_rd_word[DATA_BITS+1:DATA_BITS];
    assign rd_valid = !w_empty;
    assign overrun  = r_overrun;
    assign busy     = (r_state != IDLE) && (r_state != WAIT_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb_uart_rx_engine: directed checks of the UART receive engine, 8E1, 16 clk/bit.
module tb_uart_rx_engine;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rd_data;
    logic [1:0] rd_err;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       overrun;
    logic       clr_overrun = 1'b0;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    logic busy_log [2048];

    always #5 clk = ~clk;

    uart_rx_engine #(
        .CLK_PER_BIT(CPB),
        .DATA_BITS  (8),
        .PARITY_MODE(2),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .overrun    (overrun),
        .clr_overrun(clr_overrun),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Frame bits, LSB sent first: start, data[7:0], even parity (optionally flipped), stop
    function automatic logic [15:0] make_frame(input logic [7:0] d, input logic pflip, input logic stop);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
        f[9] = (^d) ^ pflip;
        f[10] = stop;
        return f;
    endfunction

    // Drive one pin value per cycle; first_valid = loop index where rd_valid first seen high
    task automatic send_bits(input logic [15:0] bits, input int nbits, input int glitch,
                             input int tail, input logic tail_lvl, output int first_valid);
        logic v;
        first_valid = -1;
        for (int c = 0; c < nbits * CPB + tail; c++) begin
            @(posedge clk);
            #1;
            v = (c < nbits * CPB) ? bits[c / CPB] : tail_lvl;
            rx = (c == glitch) ? ~v : v;
            @(negedge clk);
            busy_log[c] = busy;
            if (rd_valid && first_valid < 0) first_valid = c;
        end
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        int fv;
        int nbusy;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", rd_valid, 0);
        check_val("rst_data", rd_data, 0);
        check_val("rst_err", rd_err, 0);
        check_val("rst_overrun", overrun, 0);
        check_val("rst_busy", busy, 0);
        reset_n = 1'b1;
        idle_cycles(5);

        // Good frame 0x41: valid one cycle after stop sample (+2 sync offset in loop index)
        send_bits(make_frame(8'h41, 1'b0, 1'b1), 11, -1, 4, 1'b1, fv);
        check_val("good_latency", fv, HALF + 10 * CPB + 3 + MAJ);
        check_val("good_data", rd_data, 8'h41);
        check_val("good_err", rd_err, 2'b00);
        pop_one();
        check_val("good_popped", rd_valid, 0);

        // Bad parity
        send_bits(make_frame(8'h41, 1'b1, 1'b1), 11, -1, 4, 1'b1, fv);
        check_val("par_valid", rd_valid, 1);
        check_val("par_data", rd_data, 8'h41);
        check_val("par_err", rd_err, 2'b10);
        pop_one();

        // Break: stop low, line held low 40 bit times
        send_bits(make_frame(8'h41, 1'b0, 1'b0), 11, -1, 40 * CPB, 1'b0, fv);
        nbusy = 0;
        for (int c = 11 * CPB; c < 51 * CPB; c++) if (busy_log[c]) nbusy++;
        check_val("brk_no_restart", nbusy, 0);
        idle_cycles(20);
        check_val("brk_valid", rd_valid, 1);
        check_val("brk_data", rd_data, 8'h41);
        check_val("brk_err", rd_err, 2'b01);
        pop_one();
        check_val("brk_one_entry", rd_valid, 0);

        // False start: 6-cycle low pulse
        send_bits(16'h0000, 0, -1, 6, 1'b0, fv);
        send_bits(16'h0000, 0, -1, 30, 1'b1, fv);
        check_val("fs_busy_at_mid", busy_log[HALF + 2 + MAJ - 6], 1);
        check_val("fs_busy_after", busy_log[HALF + 3 + MAJ - 6], 0);
        check_val("fs_no_write", rd_valid, 0);

        // Overrun: five frames with no consumer
        for (int i = 1; i <= 5; i++)
            send_bits(make_frame(8'(i), 1'b0, 1'b1), 11, -1, 4, 1'b1, fv);
        check_val("ovr_set", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check_val($sformatf("ovr_pop%0d_valid", i), rd_valid, 1);
            check_val($sformatf("ovr_pop%0d_data", i), rd_data, i);
            pop_one();
        end
        check_val("ovr_empty", rd_valid, 0);
        check_val("ovr_sticky", overrun, 1);
        @(posedge clk);
        #1 clr_overrun = 1'b1;
        @(posedge clk);
        #1 clr_overrun = 1'b0;
        @(negedge clk);
        check_val("ovr_cleared", overrun, 0);

        // Glitch at mid of data bit 3 of 0x55 (pin cycle 4*CPB+HALF)
        send_bits(make_frame(8'h55, 1'b0, 1'b1), 11, 4 * CPB + HALF, 4, 1'b1, fv);
        check_val("glt_valid", rd_valid, 1);
        check_val("glt_data", rd_data, (MAJ != 0) ? 8'h55 : 8'h5D);
        check_val("glt_err", rd_err, (MAJ != 0) ? 2'b00 : 2'b10);
        pop_one();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
